// File: rtl/multiplexor_display.sv
// multiplexor_display
//   Time-multiplexed driver for N_DIGITOS common-anode 7-segment digits.
//   It scans one digit per slot of DIV_TICK cycles and keeps all anodes off
//   for the first T_APAGADO cycles of every slot, so the previous digit does not ghost.
//   The inputs are captured once per frame when slot 0 is entered, so a frame never
//   mixes old and new values. The block also handles decimal points and optional
//   leading-zero blanking, and gives a one-cycle pulse at the end of each frame.
//
//   Optional feature macro: DIMMING_EN. It adds the brillo[3:0] port. Brillo shortens
//   the anode on-window in steps of PASO = (DIV_TICK-T_APAGADO)/15 cycles.
//   15 means the full window and 0 means dark. Brillo is sampled with the frame snapshot.
//
// Ports
//   relojete        in   system clock, posedge
//   reset           in   synchronous, active-high
//   digitos         in   N_DIGITOS*ANCHO, digit i at [i*ANCHO +: ANCHO], digit 0 = units
//   puntos          in   decimal point request per digit
//   supresion_ceros in   1: blank leading zeros (digit 0 is never blanked)
//   brillo          in   [3:0] brightness, only when DIMMING_EN is defined
//   numero          out  code of the digit currently scanned
//   punto           out  decimal point of the current digit (polarity per ACTIVO_BAJO)
//   segmentos       out  anode enables, bit i drives digit i (polarity per ACTIVO_BAJO)
//   indice          out  current slot index
//   fin_barrido     out  1-cycle pulse on the last cycle of each frame
module multiplexor_display #(
  parameter int N_DIGITOS   = 4,
  parameter int ANCHO       = 4,
  parameter int DIV_TICK    = 250,
  parameter int T_APAGADO   = 2,
  parameter int ACTIVO_BAJO = 1
) (
  input  logic                         relojete,
  input  logic                         reset,
  input  logic [N_DIGITOS*ANCHO-1:0]   digitos,
  input  logic [N_DIGITOS-1:0]         puntos,
  input  logic                         supresion_ceros,
`ifdef DIMMING_EN
  input  logic [3:0]                   brillo,
`endif
  output logic [ANCHO-1:0]             numero,
  output logic                         punto,
  output logic [N_DIGITOS-1:0]         segmentos,
  output logic [$clog2(N_DIGITOS)-1:0] indice,
  output logic                         fin_barrido
);

  localparam int IW = $clog2(N_DIGITOS);
  localparam int PW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam logic [PW-1:0] P_ULT = PW'(DIV_TICK - 1);
  localparam logic [PW-1:0] P_ON  = PW'(T_APAGADO);
  localparam logic [IW-1:0] I_ULT = IW'(N_DIGITOS - 1);
`ifdef DIMMING_EN
  localparam int PASO = (DIV_TICK - T_APAGADO) / 15;
`endif

  // Converts a logical "on" to the pin level.
  function automatic logic a_pin(input logic on);
    return (ACTIVO_BAJO != 0) ? ~on : on;
  endfunction

  function automatic logic [N_DIGITOS-1:0] a_pines(input logic [N_DIGITOS-1:0] on);
    return (ACTIVO_BAJO != 0) ? ~on : on;
  endfunction

  // Digit i is blanked when it and every higher digit are zero. Digit 0 is never blanked.
  function automatic logic [N_DIGITOS-1:0] mascara_blanco(
    input logic [N_DIGITOS*ANCHO-1:0] d,
    input logic                       sup
  );
    logic [N_DIGITOS-1:0] m;
    logic                 altos_cero;
    m          = '0;
    altos_cero = 1'b1;
    for (int i = N_DIGITOS - 1; i >= 1; i--) begin
      altos_cero = altos_cero & (d[i*ANCHO +: ANCHO] == '0);
      m[i]       = sup & altos_cero;
    end
    return m;
  endfunction

  logic [PW-1:0]              p;
  logic                       arranque;
  logic [N_DIGITOS*ANCHO-1:0] sh_dig;
  logic [N_DIGITOS-1:0]       sh_pts;
  logic                       sh_sup;
`ifdef DIMMING_EN
  logic [3:0]                 sh_brillo;
  logic [3:0]                 brillo_e;
`endif

  logic [PW-1:0]              p_p0;
  logic [IW-1:0]              idx_p0;
  logic                       vivo_p0;
  logic                       carga_p0;
  logic [N_DIGITOS*ANCHO-1:0] dig_e;
  logic [N_DIGITOS-1:0]       pts_e;
  logic                       sup_e;
  logic [N_DIGITOS-1:0]       blanco_p0;
  logic [ANCHO-1:0]           num_p0;
  logic                       pto_p0;
  logic                       blk_p0;
  logic                       anodo_on_p0;
  logic [N_DIGITOS-1:0]       anodos_p0;
  logic                       fin_p0;

  // Stage p0: next scan position, and the outputs that belong to it.
  // The outputs are registered from the next position, so they line up with (p, indice).
  // On entry to slot 0, and on the first cycle after reset, the live inputs are
  // used. These are the same values the snapshot captures on that edge.
  always_comb begin
    p_p0   = (p == P_ULT) ? '0 : p + 1'b1;
    idx_p0 = indice;
    if (p == P_ULT) begin
      idx_p0 = (indice == I_ULT) ? '0 : indice + 1'b1;
    end
    vivo_p0  = arranque | ((p_p0 == '0) & (idx_p0 == '0));
    carga_p0 = arranque | (p_p0 == '0);

    dig_e = vivo_p0 ? digitos         : sh_dig;
    pts_e = vivo_p0 ? puntos          : sh_pts;
    sup_e = vivo_p0 ? supresion_ceros : sh_sup;
`ifdef DIMMING_EN
    brillo_e = vivo_p0 ? brillo : sh_brillo;
`endif

    blanco_p0 = mascara_blanco(dig_e, sup_e);
    num_p0    = '0;
    pto_p0    = 1'b0;
    blk_p0    = 1'b0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (idx_p0 == IW'(i)) begin
        num_p0 = dig_e[i*ANCHO +: ANCHO];
        pto_p0 = pts_e[i];
        blk_p0 = blanco_p0[i];
      end
    end

    anodo_on_p0 = (p_p0 >= P_ON) & ~blk_p0;
`ifdef DIMMING_EN
    // 15 is special-cased so the window stays full even when the slot is not a multiple of 15.
    if (brillo_e != 4'd15) begin
      anodo_on_p0 = anodo_on_p0 &
                    ((int'(p_p0) - T_APAGADO) < (int'(brillo_e) * PASO));
    end
`endif

    anodos_p0 = '0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      anodos_p0[i] = anodo_on_p0 & (idx_p0 == IW'(i));
    end

    fin_p0 = (idx_p0 == I_ULT) & (p_p0 == P_ULT);
  end

  // Stage p1: registered scan state, snapshot and pin outputs.
  always_ff @(posedge relojete) begin
    if (reset) begin
      p           <= '0;
      indice      <= '0;
      arranque    <= 1'b1;
      segmentos   <= a_pines('0);
      numero      <= '0;
      punto       <= a_pin(1'b0);
      fin_barrido <= 1'b0;
      sh_dig      <= '0;
      sh_pts      <= '0;
      sh_sup      <= 1'b0;
`ifdef DIMMING_EN
      sh_brillo   <= '0;
`endif
    end else begin
      p           <= p_p0;
      indice      <= idx_p0;
      arranque    <= 1'b0;
      segmentos   <= a_pines(anodos_p0);
      fin_barrido <= fin_p0;
      if (vivo_p0) begin
        sh_dig    <= digitos;
        sh_pts    <= puntos;
        sh_sup    <= supresion_ceros;
`ifdef DIMMING_EN
        sh_brillo <= brillo;
`endif
      end
      if (carga_p0) begin
        numero <= num_p0;
        punto  <= a_pin(pto_p0);
      end
    end
  end

endmodule
